// File: rtl/ghpc_pkg.sv
// Shared helpers for the GHPC LUT gadget: table sizing, truth-table bit lookup, share-pair type.
package ghpc_pkg;

   localparam int unsigned LutMaxW  = 4096;
   localparam int unsigned LutIdxW  = $clog2(LutMaxW);

   typedef struct packed {
      logic s0;
      logic s1;
   } share_pair_t;

   function automatic int unsigned ghpc_ne(input int unsigned n_in);
      return 32'd1 << n_in;
   endfunction

   // Bit k of F evaluated at table entry e; the table is stored entry-major.
   function automatic logic lut_bit(input logic [LutMaxW-1:0] lut, input int unsigned e,
                                    input int unsigned k, input int unsigned n_out);
      return lut[LutIdxW'(e * n_out + k)];
   endfunction

endpackage

// File: rtl/ghpc_sel_cell.sv
// One table entry of the GHPC stage 2: one-hot compare against x_s1_eff, AND gating, register.
module ghpc_sel_cell
   import ghpc_pkg::*;
#(
   parameter int unsigned N_IN  = 2,
   parameter int unsigned N_OUT = 1,
   parameter int unsigned E     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_IN-1:0]  x_s1_eff,
   input  logic [N_OUT-1:0] s1_row,
   output logic [N_OUT-1:0] s2
);

   logic sel;

   assign sel = (x_s1_eff == N_IN'(E));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2 <= '0;
      end else if (en) begin
         s2 <= {N_OUT{sel}} & s1_row;
      end
   end

endmodule

// File: rtl/ghpc_lut_gadget.sv
// First-order GHPC gadget for an arbitrary N_IN->N_OUT truth table, latency 2, throughput 1.
// GHPC_OPT_REGS_EN registers x_s1 and r internally so both output shares align with out_valid.
module ghpc_lut_gadget
   import ghpc_pkg::*;
#(
   parameter int unsigned                     N_IN  = 2,
   parameter int unsigned                     N_OUT = 1,
   parameter logic [(2**N_IN)*N_OUT-1:0]      LUT   = 4'b1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [N_IN-1:0]  x_s0,
   input  logic [N_IN-1:0]  x_s1,
   input  logic [N_OUT-1:0] r,
   output logic             out_valid,
   output logic [N_OUT-1:0] y_s0,
   output logic [N_OUT-1:0] y_s1
);

   localparam int unsigned          NE     = ghpc_ne(N_IN);
   localparam logic [LutMaxW-1:0]   LutExt = LutMaxW'(LUT);

   logic [NE-1:0][N_OUT-1:0] s1_d;
   logic [NE-1:0][N_OUT-1:0] s1_q;
   logic [NE-1:0][N_OUT-1:0] s2;
   logic [N_IN-1:0]          x_s1_eff;
   logic                     v1_q;
   logic                     out_valid_q;

   // Stage 1: the table re-indexed by share 0 and masked with r; only constants meet x_s0 here.
   for (genvar e = 0; e < NE; e++) begin : g_s1
      for (genvar k = 0; k < N_OUT; k++) begin : g_bit
         assign s1_d[e][k] = lut_bit(LutExt, 32'(N_IN'(e) ^ x_s0), k, N_OUT) ^ r[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
      end else if (in_valid) begin
         s1_q <= s1_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         v1_q        <= in_valid;
         out_valid_q <= v1_q;
      end
   end

`ifdef GHPC_OPT_REGS_EN
   logic [N_IN-1:0]  x_s1_q;
   logic [N_OUT-1:0] r1_q;
   logic [N_OUT-1:0] r2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_s1_q <= '0;
         r1_q   <= '0;
         r2_q   <= '0;
      end else begin
         if (in_valid) begin
            x_s1_q <= x_s1;
            r1_q   <= r;
         end
         if (v1_q) begin
            r2_q <= r1_q;
         end
      end
   end

   assign x_s1_eff = x_s1_q;
   assign y_s0     = r2_q;
`else
   // Caller presents x_s1 one cycle late and aligns share 0 itself.
   assign x_s1_eff = x_s1;
   assign y_s0     = r;
`endif

   for (genvar e = 0; e < NE; e++) begin : g_cell
      ghpc_sel_cell #(
         .N_IN  (N_IN),
         .N_OUT (N_OUT),
         .E     (e)
      ) u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (v1_q),
         .x_s1_eff (x_s1_eff),
         .s1_row   (s1_q[e]),
         .s2       (s2[e])
      );
   end

   always_comb begin
      y_s1 = '0;
      for (int e = 0; e < NE; e++) begin
         y_s1 = y_s1 ^ s2[e];
      end
   end

   assign out_valid = out_valid_q;

endmodule
